// File: rtl/lock_access_ctrl.sv
// lock_access_ctrl: access-policy controller for the keypad password lock.
// Consumes verification events, drives unlock / lockout / alarm and gates
// keypad entry. Timed behaviour counts an external 1-cycle tick strobe.
// Optional feature: define LOCK_BACKOFF_EN to double the lockout duration on
// each consecutive lockout (1x, 2x, 4x, 8x, 8x ...) until a match in LOCKED.
module lock_access_ctrl #(
  parameter int MAX_FAILS   = 3,
  parameter int FAIL_W      = 2,
  parameter int OPEN_TICKS  = 5000,
  parameter int LOCK_TICKS  = 30000,
  parameter int ALARM_TICKS = 1000,
  parameter int TIMER_W     = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               tick,
  input  logic               code_set,
  input  logic               verify_done,
  input  logic               match,
  input  logic               manual_lock,
  output logic               allow_input,
  output logic               unlock,
  output logic               lockout,
  output logic               alarm,
  output logic [FAIL_W-1:0]  fail_count,
  output logic [TIMER_W-1:0] lock_remaining,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    S_NOCODE  = 2'd0,
    S_LOCKED  = 2'd1,
    S_OPEN    = 2'd2,
    S_LOCKOUT = 2'd3
  } state_t;

  localparam logic [TIMER_W-1:0] OPEN_T  = TIMER_W'(OPEN_TICKS);
  localparam logic [TIMER_W-1:0] LOCK_T  = TIMER_W'(LOCK_TICKS);
  localparam logic [TIMER_W-1:0] ALARM_T = TIMER_W'(ALARM_TICKS);
  localparam logic [FAIL_W-1:0]  MAX_F   = FAIL_W'(MAX_FAILS);

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TIMER_W-1:0] dur_q, dur_d;
  logic [FAIL_W-1:0]  fail_q, fail_d;
  logic [FAIL_W-1:0]  fail_inc;
  logic [TIMER_W-1:0] lock_dur;
  logic               expire;
  logic               load;

  logic               allow_q, allow_d;
  logic               unlock_q, unlock_d;
  logic               lockout_q, lockout_d;
  logic               alarm_q, alarm_d;
  logic [TIMER_W-1:0] rem_q, rem_d;

`ifdef LOCK_BACKOFF_EN
  logic [1:0] level_q, level_d;
`endif

  // Lockout duration for the next LOCKOUT entry.
  always_comb begin
`ifdef LOCK_BACKOFF_EN
    lock_dur = LOCK_T << level_q;
`else
    lock_dur = LOCK_T;
`endif
  end

  // Next-state, timer and output decode; a load on this edge suppresses the tick.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    dur_d    = dur_q;
    fail_d   = fail_q;
    load     = 1'b0;
`ifdef LOCK_BACKOFF_EN
    level_d  = level_q;
`endif
    expire   = tick && (timer_q == TIMER_W'(1));
    fail_inc = (fail_q == MAX_F) ? fail_q : fail_q + FAIL_W'(1);

    case (state_q)
      S_NOCODE: begin
        if (code_set) begin
          state_d = S_LOCKED;
          timer_d = '0;
          load    = 1'b1;
        end
      end
      S_LOCKED: begin
        if (verify_done) begin
          if (match) begin
            state_d = S_OPEN;
            timer_d = OPEN_T;
            fail_d  = '0;
            load    = 1'b1;
`ifdef LOCK_BACKOFF_EN
            level_d = '0;
`endif
          end else begin
            fail_d = fail_inc;
            if (fail_inc == MAX_F) begin
              state_d = S_LOCKOUT;
              timer_d = lock_dur;
              dur_d   = lock_dur;
              load    = 1'b1;
`ifdef LOCK_BACKOFF_EN
              level_d = (level_q == 2'd3) ? level_q : level_q + 2'd1;
`endif
            end
          end
        end
      end
      S_OPEN: begin
        if (manual_lock) begin
          state_d = S_LOCKED;
          timer_d = '0;
          load    = 1'b1;
        end else if (verify_done && match) begin
          timer_d = OPEN_T;
          load    = 1'b1;
        end else if (expire) begin
          state_d = S_LOCKED;
        end
      end
      S_LOCKOUT: begin
        if (expire) begin
          state_d = S_LOCKED;
          fail_d  = '0;
        end
      end
      default: state_d = S_NOCODE;
    endcase

    if (!load && tick && (timer_q != '0)) begin
      timer_d = timer_q - TIMER_W'(1);
    end

    // Outputs are decoded from next-state values so they are registered in step.
    allow_d   = (state_d != S_LOCKOUT);
    unlock_d  = (state_d == S_OPEN);
    lockout_d = (state_d == S_LOCKOUT);
    alarm_d   = lockout_d && ((dur_d - timer_d) < ALARM_T);
    rem_d     = lockout_d ? timer_d : '0;
  end

  // State, timer and registered outputs; async active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_NOCODE;
      timer_q   <= '0;
      dur_q     <= '0;
      fail_q    <= '0;
      allow_q   <= 1'b0;
      unlock_q  <= 1'b0;
      lockout_q <= 1'b0;
      alarm_q   <= 1'b0;
      rem_q     <= '0;
`ifdef LOCK_BACKOFF_EN
      level_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      dur_q     <= dur_d;
      fail_q    <= fail_d;
      allow_q   <= allow_d;
      unlock_q  <= unlock_d;
      lockout_q <= lockout_d;
      alarm_q   <= alarm_d;
      rem_q     <= rem_d;
`ifdef LOCK_BACKOFF_EN
      level_q   <= level_d;
`endif
    end
  end

  assign allow_input    = allow_q;
  assign unlock         = unlock_q;
  assign lockout        = lockout_q;
  assign alarm          = alarm_q;
  assign fail_count     = fail_q;
  assign lock_remaining = rem_q;
  assign state          = state_q;

endmodule

// File: tb/tb_lock_access_ctrl.sv
// Testbench for lock_access_ctrl: directed scenarios followed by random
// stimulus, all compared against a behavioural reference model.
module tb_lock_access_ctrl;

  localparam int MAXF  = 3;
  localparam int OPENT = 4;
  localparam int LOCKT = 6;
  localparam int ALRMT = 2;
`ifdef LOCK_BACKOFF_EN
  localparam int EXP_DUR2 = 12;
`else
  localparam int EXP_DUR2 = 6;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        tick, code_set, verify_done, match, manual_lock;
  logic        allow_input, unlock, lockout, alarm;
  logic [1:0]  fail_count;
  logic [15:0] lock_remaining;
  logic [1:0]  state;

  lock_access_ctrl #(
    .MAX_FAILS  (MAXF),
    .FAIL_W     (2),
    .OPEN_TICKS (OPENT),
    .LOCK_TICKS (LOCKT),
    .ALARM_TICKS(ALRMT),
    .TIMER_W    (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .tick          (tick),
    .code_set      (code_set),
    .verify_done   (verify_done),
    .match         (match),
    .manual_lock   (manual_lock),
    .allow_input   (allow_input),
    .unlock        (unlock),
    .lockout       (lockout),
    .alarm         (alarm),
    .fail_count    (fail_count),
    .lock_remaining(lock_remaining),
    .state         (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  // Reference model: mode 0..3, ticks left, ticks spent in lockout,
  // consecutive fails, lockouts since the last accepted match.
  int m_st, m_left, m_elapsed, m_fails, m_nlock;
  int e_allow, e_unlock, e_lockout, e_alarm, e_rem;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lock_dur(input int n);
`ifdef LOCK_BACKOFF_EN
    return LOCKT * (1 << ((n > 3) ? 3 : n));
`else
    return LOCKT + 0 * n;
`endif
  endfunction

  task automatic model_outputs();
    e_allow   = (m_st != 3) ? 1 : 0;
    e_unlock  = (m_st == 2) ? 1 : 0;
    e_lockout = (m_st == 3) ? 1 : 0;
    e_alarm   = (m_st == 3 && m_elapsed < ALRMT) ? 1 : 0;
    e_rem     = (m_st == 3) ? m_left : 0;
  endtask

  task automatic model_reset();
    m_st = 0; m_left = 0; m_elapsed = 0; m_fails = 0; m_nlock = 0;
    e_allow = 0; e_unlock = 0; e_lockout = 0; e_alarm = 0; e_rem = 0;
  endtask

  task automatic model_update(input bit t, input bit cs, input bit vd,
                              input bit mt, input bit ml);
    bit loaded = 0;
    int prev   = m_st;
    bit ex     = t && (m_left == 1);
    case (prev)
      0: if (cs) begin m_st = 1; m_left = 0; loaded = 1; end
      1: if (vd) begin
           if (mt) begin
             m_st = 2; m_left = OPENT; m_fails = 0; m_nlock = 0; loaded = 1;
           end else begin
             if (m_fails < MAXF) m_fails++;
             if (m_fails == MAXF) begin
               m_st = 3; m_left = lock_dur(m_nlock); m_nlock++;
               m_elapsed = 0; loaded = 1;
             end
           end
         end
      2: if (ml) begin m_st = 1; m_left = 0; loaded = 1; end
         else if (vd && mt) begin m_left = OPENT; loaded = 1; end
         else if (ex) m_st = 1;
      default: if (ex) begin m_st = 1; m_fails = 0; end
    endcase
    if (!loaded && t && m_left > 0) begin
      m_left--;
      if (prev == 3) m_elapsed++;
    end
    model_outputs();
  endtask

  task automatic check_all();
    chk("state",    int'(state),          m_st);
    chk("allow",    int'(allow_input),    e_allow);
    chk("unlock",   int'(unlock),         e_unlock);
    chk("lockout",  int'(lockout),        e_lockout);
    chk("alarm",    int'(alarm),          e_alarm);
    chk("fails",    int'(fail_count),     m_fails);
    chk("lock_rem", int'(lock_remaining), e_rem);
  endtask

  // Drive at the falling edge, apply on the rising edge, check at the next falling edge.
  task automatic step(input bit t, input bit cs, input bit vd, input bit mt, input bit ml);
    tick = t; code_set = cs; verify_done = vd; match = mt; manual_lock = ml;
    @(posedge clk);
    model_update(t, cs, vd, mt, ml);
    @(negedge clk);
    check_all();
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic do_reset();
    tick = 0; code_set = 0; verify_done = 0; match = 0; manual_lock = 0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_lockout_end();
    for (int i = 0; i < 64 && m_st == 3; i++) step(1, 0, 0, 0, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    tick = 0; code_set = 0; verify_done = 0; match = 0; manual_lock = 0;
    model_reset();
    @(negedge clk);
    check_all();
    reset_n = 1'b1;

    // Code entry then a successful verify and door timeout.
    step(1, 1, 0, 0, 0);
    chk("t1_state", int'(state), 1);
    chk("t1_allow", int'(allow_input), 1);
    step(1, 0, 1, 1, 0);
    chk("t2_state", int'(state), 2);
    chk("t2_unlock", int'(unlock), 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    chk("t2_still_open", int'(state), 2);
    step(1, 0, 0, 0, 0);
    chk("t2_closed", int'(state), 1);
    chk("t2_unlock0", int'(unlock), 0);

    // Three mismatches into lockout, alarm window, expiry.
    for (int i = 1; i <= 3; i++) begin
      step(1, 0, 1, 0, 0);
      chk("t3_fails", int'(fail_count), i);
    end
    chk("t3_state", int'(state), 3);
    chk("t3_rem", int'(lock_remaining), 6);
    chk("t3_alarm_on", int'(alarm), 1);
    step(1, 0, 0, 0, 0);
    chk("t3_alarm_t1", int'(alarm), 1);
    step(1, 0, 0, 0, 0);
    chk("t3_alarm_off", int'(alarm), 0);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 1);
    chk("t3_unlocked", int'(state), 1);
    chk("t3_fails0", int'(fail_count), 0);

    // Second lockout without a match in between.
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0);
    chk("t6_dur2", int'(lock_remaining), EXP_DUR2);

    // Reset in the middle of lockout.
    for (int i = 0; i < 20 && e_rem > 3; i++) step(1, 0, 0, 0, 0);
    chk("t5_rem3", int'(lock_remaining), 3);
    do_reset();

    // Two lockouts, a match, a manual relock racing a match, then a fresh lockout.
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0);
    wait_lockout_end();
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0);
    chk("t6_dur2b", int'(lock_remaining), EXP_DUR2);
    wait_lockout_end();
    step(1, 0, 1, 1, 0);
    chk("t4_open", int'(state), 2);
    step(1, 0, 1, 1, 1);
    chk("t4_state", int'(state), 1);
    chk("t4_unlock", int'(unlock), 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0);
    chk("t6_dur_after_match", int'(lock_remaining), 6);
    wait_lockout_end();

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 5,
             $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 50,
             $urandom_range(0, 99) < 5);
      end
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
